vga_tx_queue: RTL
=================

Name: vga_tx_queue

Overview:
- Character pacing stage directly upstream of the VGA text terminal.
- Accepts byte writes from the CPU's memory-mapped output port and buffers them in a FIFO.
- Replays each byte to the terminal on current_o, framed by a writeBusy_o high pulse; the terminal consumes the byte on the falling edge of that pulse.
- Guarantees pulse widths and inter-character gaps that the terminal's 2-flop input sampler and its 64-cycle line-clean sequence require.

Parameters:
DEPTH, 16, FIFO entries (power of 2)
HOLD_CYCLES, 4, cycles writeBusy_o stays high per character (min 3)
GAP_CYCLES, 4, idle cycles after busy falls, normal character
NL_GAP_CYCLES, 72, idle cycles after busy falls when character was 0x0A (covers 64-cycle line clean plus margin)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (rst==0 resets on posedge clk)
we_i  in  1  CPU write strobe, one byte per cycle high
data_i  in  8  CPU write byte
full_o  out  1  FIFO full; CPU must poll before writing
empty_o  out  1  FIFO empty and transmitter idle
count_o  out  5  bytes held in FIFO (0..DEPTH)
overflow_o  out  1  sticky: a write was dropped
clr_ovf_i  in  1  clears overflow_o
current_o  out  8  byte presented to terminal (drives its current_i)
writeBusy_o  out  1  framing pulse (drives terminal writeBusy_i)

Behaviour:
- Reset (rst==0 at posedge): FIFO pointers 0, count_o=0, full_o=0, empty_o=1, overflow_o=0, current_o=8'h00, writeBusy_o=0, FSM=IDLE, timer=0. Reset mid-pulse drops writeBusy_o to 0 in the same edge; the buffered contents are lost.
- Push: accepted when we_i=1 and (count<DEPTH or a pop occurs in the same cycle). Otherwise the byte is dropped and overflow_o is set. clr_ovf_i clears overflow_o; a simultaneous drop wins (stays 1).
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- full_o = (count==DEPTH); empty_o = (count==0 && FSM==IDLE). Both are registered along with count.
- FSM states: IDLE, PULSE, GAP. A down-counter timer is 7 bits wide.
- IDLE, FIFO non-empty: pop the head byte.
  - 0x0D: discard, stay IDLE; the next pop is allowed the following cycle.
  - Any other byte: current_o<=byte, writeBusy_o<=1, timer<=HOLD_CYCLES-1, go to PULSE.
- PULSE:
  - timer>0: decrement.
  - timer==0: writeBusy_o<=0, timer<=(current_o==8'h0A)?NL_GAP_CYCLES-1:GAP_CYCLES-1, go to GAP.
- GAP: decrement; at timer==0 go to IDLE.
- current_o is held stable from the pop until the next non-CR pop, which is at least GAP_CYCLES after the falling edge. This guarantees the terminal sees a stable byte when its 2-stage sampler detects the fall.
- Latency: a write accepted at edge t into an empty idle queue gives writeBusy_o=1 after edge t+1 (byte stored at t, popped at t+1). writeBusy_o falls HOLD_CYCLES edges later.
- Throughput: one character per HOLD_CYCLES+GAP_CYCLES cycles (8 by default); a newline takes HOLD_CYCLES+NL_GAP_CYCLES.
- 0x08 (backspace) and all other bytes are passed through unmodified; only 0x0D is filtered.

Decomposition:
- Shared defines file gains:
  - active-low reset constant (RstnEnable=1'b0)
  - character constants: CHAR_LF=8'h0A, CHAR_CR=8'h0D, CHAR_BS=8'h08
  - default timing constants: HOLD, GAP, NL_GAP
- One sub-module: sync_fifo (parameterised width/depth, push/pop/count/full, same clk/rst), reusable for the serial port.
- The FSM and timer stay in vga_tx_queue.

Test Plan:
- Reset, then write 0x41 once → writeBusy_o high for exactly 4 cycles starting 2 edges after the write, current_o=0x41 throughout and for ≥4 cycles after the fall; empty_o returns to 1 at 8 cycles.
- Burst-write 0x41,0x42,0x43 on consecutive cycles → three pulses, rising edges 8 cycles apart, current_o 0x41/0x42/0x43 in order, count_o peaks at 2.
- Write 0x0A then 0x41 → busy falls for 0x0A, next rise is ≥72 cycles later; write 0x0D,0x42 → only 0x42 is pulsed, 1 cycle later than the no-CR case.
- Write 17 bytes while the transmitter is stalled (first byte in PULSE) → 16 buffered, full_o=1, the 17th is dropped, overflow_o=1; clr_ovf_i clears it. Write while full with a simultaneous pop → accepted, count stays 16.
- Drive rst=0 mid-PULSE with 5 bytes queued → next edge: writeBusy_o=0, count_o=0, current_o=0x00, empty_o=1; no further pulses after rst=1.

Source files
------------

// File: rtl/vga_tx_queue_pkg.sv
// vga_tx_queue_pkg: shared reset polarity, character codes, timing defaults and FSM states
package vga_tx_queue_pkg;
  localparam logic RstnEnable = 1'b0;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam int HOLD = 4;
  localparam int GAP = 4;
  localparam int NL_GAP = 72;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;
endpackage

// File: rtl/vga_tx_queue_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full and same-cycle push-while-full-and-pop
module sync_fifo
  import vga_tx_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_n,
  output logic                     o_full,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count, w_count_n;
  logic r_full, w_push, w_pop;
  always_comb begin
    w_pop = i_pop && (r_count != '0);
    w_push = i_push && (!r_full || w_pop);
    w_count_n = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end
  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= w_count_n;
      r_full <= (w_count_n == (AW+1)'(DEPTH));
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  assign o_count_n = w_count_n;
  assign o_full = r_full;
  assign o_drop = i_push && !w_push;
endmodule

// File: rtl/vga_tx_queue.sv
// vga_tx_queue: buffers CPU bytes and paces them to the VGA terminal as writeBusy_o-framed characters
module vga_tx_queue
  import vga_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HOLD_CYCLES = HOLD,
  parameter int GAP_CYCLES = GAP,
  parameter int NL_GAP_CYCLES = NL_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [7:0]             data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  input  logic                   clr_ovf_i,
  output logic [7:0]             current_o,
  output logic                   writeBusy_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t r_state, w_state_n;
  logic [6:0] r_timer, w_timer_n;
  logic [7:0] r_cur, w_cur_n, w_head;
  logic r_busy, w_busy_n, r_ovf, r_empty, w_pop, w_drop;
  logic [CW-1:0] w_count, w_count_n;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (we_i),
    .i_pop    (w_pop),
    .i_data   (data_i),
    .o_data   (w_head),
    .o_count  (w_count),
    .o_count_n(w_count_n),
    .o_full   (full_o),
    .o_drop   (w_drop)
  );
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_cur_n = r_cur;
    w_busy_n = r_busy;
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: if (w_count != '0) begin
        w_pop = 1'b1;
        if (w_head != CHAR_CR) begin
          w_cur_n = w_head;
          w_busy_n = 1'b1;
          w_timer_n = 7'(HOLD_CYCLES - 1);
          w_state_n = ST_PULSE;
        end
      end
      ST_PULSE: if (r_timer != '0) w_timer_n = r_timer - 7'd1;
      else begin
        w_busy_n = 1'b0;
        w_timer_n = (r_cur == CHAR_LF) ? 7'(NL_GAP_CYCLES - 1) : 7'(GAP_CYCLES - 1);
        w_state_n = ST_GAP;
      end
      // leave as the count reaches zero so the next pop lands exactly GAP cycles after the fall
      ST_GAP: begin
        w_timer_n = (r_timer <= 7'd1) ? 7'd0 : r_timer - 7'd1;
        w_state_n = (r_timer <= 7'd1) ? ST_IDLE : ST_GAP;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_cur <= 8'h00;
      r_busy <= 1'b0;
      r_ovf <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_cur <= w_cur_n;
      r_busy <= w_busy_n;
      r_ovf <= w_drop ? 1'b1 : (clr_ovf_i ? 1'b0 : r_ovf);
      r_empty <= (w_count_n == '0) && (w_state_n == ST_IDLE);
    end
  end
  assign empty_o = r_empty;
  assign count_o = w_count;
  assign overflow_o = r_ovf;
  assign current_o = r_cur;
  assign writeBusy_o = r_busy;
endmodule
